// File: rtl/bundle_arb_pkg.sv
// Shared types and helpers for the packet-aware round-robin channel arbiter.
package bundle_arb_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  localparam int unsigned DEFAULT_DATA_W = 32;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = n - 32'd1; v > 0; v = v >> 1) begin
      r = r + 32'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first requester after ptr, found by rotating a
// doubled request vector and taking its lowest set bit.
module rr_priority_pick
  import bundle_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] grant_oh_o,
  output logic [ID_W-1:0]    grant_idx_o,
  output logic               any_o
);

  logic [2*NUM_REQ-1:0] dbl_c;
  logic [NUM_REQ-1:0]   rot_c;
  int unsigned          start_c;
  int unsigned          off_c;
  int unsigned          idx_c;

  always_comb begin
    start_c = (32'(ptr_i) + 32'd1) % NUM_REQ;
    dbl_c   = {req_i, req_i};
    rot_c   = NUM_REQ'(dbl_c >> start_c);
    off_c   = 32'd0;
    // Descending scan so the lowest set bit of the rotated vector wins.
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (rot_c[i]) off_c = 32'(i);
    end
    idx_c       = (start_c + off_c) % NUM_REQ;
    any_o       = |rot_c;
    grant_idx_o = ID_W'(idx_c);
    grant_oh_o  = any_o ? (NUM_REQ'(1) << idx_c) : '0;
  end

endmodule

// File: rtl/bundle_rr_arbiter.sv
// Shares one data channel between NUM_REQ requesters: packet-aware round-robin
// grant feeding a one-entry registered output stage.
module bundle_rr_arbiter
  import bundle_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = DEFAULT_DATA_W,
  parameter int unsigned ID_W    = clog2(NUM_REQ)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        io_in_valid,
  input  logic [NUM_REQ-1:0]        io_in_last,
  input  logic [NUM_REQ*DATA_W-1:0] io_in_data,
  output logic [NUM_REQ-1:0]        io_in_ready,
  output logic                      io_out_valid,
  input  logic                      io_out_ready,
  output logic [DATA_W-1:0]         io_out_data,
  output logic                      io_out_last,
  output logic [ID_W-1:0]           io_out_id
);

  arb_state_t          state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     lock_id_q, lock_id_d;
  logic                out_valid_q;
  logic [DATA_W-1:0]   out_data_q;
  logic                out_last_q;
  logic [ID_W-1:0]     out_id_q;

  logic [NUM_REQ-1:0]  pick_oh_c;
  logic [ID_W-1:0]     pick_idx_c;
  logic                pick_any_c;
  logic                slot_free_c;
  logic                lock_valid_c;
  logic                load_c;
  logic [ID_W-1:0]     grant_idx_c;
  logic [DATA_W-1:0]   sel_data_c;
  logic                sel_last_c;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req_i       (io_in_valid),
    .ptr_i       (rr_ptr_q),
    .grant_oh_o  (pick_oh_c),
    .grant_idx_o (pick_idx_c),
    .any_o       (pick_any_c)
  );

  // Grant decode: slot must be free; a locked packet owner excludes everyone else.
  always_comb begin
    slot_free_c  = !out_valid_q || io_out_ready;
    lock_valid_c = |(io_in_valid & (NUM_REQ'(1) << lock_id_q));
    grant_idx_c  = (state_q == LOCKED) ? lock_id_q : pick_idx_c;
    load_c       = !reset && slot_free_c &&
                   ((state_q == LOCKED) ? lock_valid_c : pick_any_c);
    io_in_ready  = load_c ? (NUM_REQ'(1) << grant_idx_c) : '0;
  end

  // Payload mux of the granted requester.
  always_comb begin
    sel_data_c = '0;
    sel_last_c = 1'b0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant_idx_c == ID_W'(i)) begin
        sel_data_c = io_in_data[i*DATA_W +: DATA_W];
        sel_last_c = io_in_last[i];
      end
    end
  end

  // Next-state: lock on a non-last beat, unlock on the owner's last beat.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    lock_id_d = lock_id_q;
    if (load_c) begin
      rr_ptr_d = grant_idx_c;
      case (state_q)
        ARB: begin
          if (!sel_last_c) begin
            lock_id_d = grant_idx_c;
            state_d   = LOCKED;
          end
        end
        LOCKED: begin
          if (sel_last_c) state_d = ARB;
        end
        default: state_d = ARB;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ARB;
      rr_ptr_q  <= ID_W'(NUM_REQ - 32'd1);
      lock_id_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      lock_id_q <= lock_id_d;
    end
  end

  // One-entry output stage; a simultaneous drain and load keeps valid high.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_id_q    <= '0;
    end else if (load_c) begin
      out_valid_q <= 1'b1;
      out_data_q  <= sel_data_c;
      out_last_q  <= sel_last_c;
      out_id_q    <= grant_idx_c;
    end else if (io_out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign io_out_valid = out_valid_q;
  assign io_out_data  = out_data_q;
  assign io_out_last  = out_last_q;
  assign io_out_id    = out_id_q;

endmodule

// File: tb/tb_bundle_rr_arbiter.sv
// Directed bench for bundle_rr_arbiter: a 4-requester instance plus a 2-requester
// instance checked against hand-computed grant order and per-id beat counters.
module tb_bundle_rr_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned IW = 2;

  logic            clock = 1'b0;
  logic            reset;
  logic [N-1:0]    in_valid, in_last, in_ready;
  logic [N*DW-1:0] in_data;
  logic            out_valid, out_ready, out_last;
  logic [DW-1:0]   out_data;
  logic [IW-1:0]   out_id;

  logic [1:0]      v2, l2, r2;
  logic [2*DW-1:0] d2;
  logic            ov2, or2, ol2;
  logic [DW-1:0]   od2;
  logic [0:0]      oid2;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  bundle_rr_arbiter #(.NUM_REQ(4), .DATA_W(32), .ID_W(2)) dut (
    .clock        (clock),
    .reset        (reset),
    .io_in_valid  (in_valid),
    .io_in_last   (in_last),
    .io_in_data   (in_data),
    .io_in_ready  (in_ready),
    .io_out_valid (out_valid),
    .io_out_ready (out_ready),
    .io_out_data  (out_data),
    .io_out_last  (out_last),
    .io_out_id    (out_id)
  );

  bundle_rr_arbiter #(.NUM_REQ(2), .DATA_W(32), .ID_W(1)) dut2 (
    .clock        (clock),
    .reset        (reset),
    .io_in_valid  (v2),
    .io_in_last   (l2),
    .io_in_data   (d2),
    .io_in_ready  (r2),
    .io_out_valid (ov2),
    .io_out_ready (or2),
    .io_out_data  (od2),
    .io_out_last  (ol2),
    .io_out_id    (oid2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_data(input int i, input logic [DW-1:0] d);
    in_data[i*DW +: DW] = d;
  endtask

  task automatic check_out(input string tag, input int id, input logic [DW-1:0] d, input logic last);
    check({tag, "_valid"}, 64'(out_valid), 64'(1));
    check({tag, "_id"},    64'(out_id),    64'(id));
    check({tag, "_data"},  64'(out_data),  64'(d));
    check({tag, "_last"},  64'(out_last),  64'(last));
  endtask

  initial begin
    int seq [2];
    int exp_ids [16];
    int e;
    logic exp_last;

    exp_ids = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 1, 1, 0, 0, 1, 1};
    reset     = 1'b1;
    in_valid  = 4'hF;
    in_last   = 4'hF;
    out_ready = 1'b1;
    in_data   = '0;
    for (int i = 0; i < 4; i++) set_data(i, 32'h100 + 32'(i));
    v2 = '0; l2 = '0; d2 = '0; or2 = 1'b1;

    // Reset state
    #1;
    check("rst_ready", 64'(in_ready), 64'(0));
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_data",  64'(out_data), 64'(0));
    check("rst_last",  64'(out_last), 64'(0));
    check("rst_id",    64'(out_id), 64'(0));
    check("rst_valid2", 64'(ov2), 64'(0));
    step();
    step();
    reset = 1'b0;

    // 1: all valid, single-beat packets -> 0,1,2,3,0
    for (int k = 0; k < 5; k++) begin
      e = k % 4;
      #1;
      check("t1_ready", 64'(in_ready), 64'(1) << e);
      step();
      check_out("t1", e, 32'h100 + 32'(e), 1'b1);
    end
    in_valid = '0;
    step();
    check("t1_drain", 64'(out_valid), 64'(0));

    // 2: req1 3-beat packet holds the channel against req2
    in_valid = 4'b0110;
    in_last  = 4'b0100;
    set_data(2, 32'hB2);
    for (int b = 0; b < 3; b++) begin
      in_last[1] = (b == 2);
      set_data(1, 32'hA0 + 32'(b));
      #1;
      check("t2_ready", 64'(in_ready), 64'(4'b0010));
      step();
      check_out("t2", 1, 32'hA0 + 32'(b), (b == 2));
    end
    in_valid = 4'b0100;
    #1;
    check("t2_ready2", 64'(in_ready), 64'(4'b0100));
    step();
    check_out("t2_req2", 2, 32'hB2, 1'b1);
    in_valid = '0;
    step();

    // 3: backpressure holds the buffered beat
    out_ready = 1'b0;
    in_valid  = 4'b0001;
    in_last   = 4'hF;
    set_data(0, 32'hDEADBEEF);
    #1;
    check("t3_ready", 64'(in_ready), 64'(4'b0001));
    step();
    check_out("t3_load", 0, 32'hDEADBEEF, 1'b1);
    in_valid = 4'b0010;
    set_data(1, 32'h11);
    for (int k = 0; k < 5; k++) begin
      #1;
      check("t3_stall_ready", 64'(in_ready), 64'(0));
      step();
      check_out("t3_hold", 0, 32'hDEADBEEF, 1'b1);
    end
    out_ready = 1'b1;
    #1;
    check("t3_release_ready", 64'(in_ready), 64'(4'b0010));
    step();
    check_out("t3_next", 1, 32'h11, 1'b1);
    in_valid = '0;
    step();
    check("t3_single", 64'(out_valid), 64'(0));

    // 4: wrap-around search from rr_ptr=3
    in_valid = 4'b1000;
    set_data(3, 32'h33);
    #1;
    check("t4_ready_a", 64'(in_ready), 64'(4'b1000));
    step();
    check_out("t4_a", 3, 32'h33, 1'b1);
    set_data(3, 32'h34);
    #1;
    check("t4_ready_wrap", 64'(in_ready), 64'(4'b1000));
    step();
    check_out("t4_wrap", 3, 32'h34, 1'b1);
    in_valid = 4'b1001;
    set_data(0, 32'h40);
    #1;
    check("t4_ready_0", 64'(in_ready), 64'(4'b0001));
    step();
    check_out("t4_0", 0, 32'h40, 1'b1);
    in_valid = '0;
    step();

    // 5: async reset while locked with a buffered beat
    in_valid = 4'b0100;
    in_last  = 4'b0000;
    set_data(2, 32'h52);
    #1;
    check("t5_ready", 64'(in_ready), 64'(4'b0100));
    step();
    check_out("t5_lock", 2, 32'h52, 1'b0);
    out_ready = 1'b0;
    in_valid  = 4'b0101;
    in_last   = 4'b0001;
    set_data(0, 32'h50);
    #1;
    check("t5_bp_ready", 64'(in_ready), 64'(0));
    #1;
    reset = 1'b1;
    #1;
    check("t5_async_valid", 64'(out_valid), 64'(0));
    check("t5_async_data",  64'(out_data), 64'(0));
    check("t5_rst_ready",   64'(in_ready), 64'(0));
    step();
    reset     = 1'b0;
    out_ready = 1'b1;
    in_last   = 4'b0101;
    #1;
    check("t5_post_ready", 64'(in_ready), 64'(4'b0001));
    step();
    check_out("t5_post", 0, 32'h50, 1'b1);
    #1;
    check("t5_rr_ready", 64'(in_ready), 64'(4'b0100));
    step();
    check_out("t5_rr", 2, 32'h52, 1'b1);
    in_valid = '0;
    step();

    // 6: two-requester build, single beats then 2-beat packets
    seq[0] = 0;
    seq[1] = 0;
    v2 = 2'b11;
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 2; i++) begin
        d2[i*DW +: DW] = {16'(i), 16'(seq[i])};
        l2[i] = (k < 8) ? 1'b1 : seq[i][0];
      end
      e = exp_ids[k];
      exp_last = (k < 8) ? 1'b1 : seq[e][0];
      #1;
      check("t6_ready", 64'(r2), 64'(1) << e);
      step();
      check("t6_valid", 64'(ov2), 64'(1));
      check("t6_id",    64'(oid2), 64'(e));
      check("t6_data",  64'(od2), 64'({16'(e), 16'(seq[e])}));
      check("t6_last",  64'(ol2), 64'(exp_last));
      seq[e]++;
    end
    v2 = '0;
    step();
    check("t6_drain", 64'(ov2), 64'(0));
    check("t6_count0", 64'(seq[0]), 64'(8));
    check("t6_count1", 64'(seq[1]), 64'(8));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
